// File: rtl/eth_rx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : eth_rx_framer
//  Purpose  : Serial-to-byte frame receiver that writes bytes into an
//             external buffer with an active-low strobe, and reports frame
//             length and overflow status.
//  Revision : 1.0  initial release
// ============================================================================
module eth_rx_framer #(
  parameter int ADDR_W     = 11,
  parameter int MAX_LEN    = 2048,
  parameter int MSB_FIRST  = 0,
  parameter int DOUBLE_BUF = 0
) (
  input  logic              sck,
  input  logic              n_rst,
  input  logic              mosi,
  input  logic              ena,
  output logic [7:0]        recv_d,
  output logic [ADDR_W-1:0] recv_a,
  output logic              recv_bank,
  output logic              n_recv_buf_we,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] c_max_len = (ADDR_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_OVF  = 2'd2
  } state_t;

  state_t            state_q;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic [2:0]        bitcnt_q;
  logic [ADDR_W:0]   count_q;
  logic              pending_q;
  logic              w_byte_done;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_d = {shift_q[6:0], mosi};
    end else begin : g_lsb_first
      assign shift_d = {mosi, shift_q[7:1]};
    end
  endgenerate

  assign w_byte_done = (bitcnt_q == 3'd7);

  // Strobe covers only the low half of sck after a completing edge, so data
  // and address are already stable when it falls and still stable when it rises.
  assign n_recv_buf_we = ~(pending_q & ~sck & ena);

  always_ff @(posedge sck or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bitcnt_q   <= 3'd0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      recv_d     <= 8'd0;
      recv_a     <= '0;
      recv_bank  <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pending_q  <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ena) begin
            state_q  <= ST_RECV;
            overflow <= 1'b0;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_q + 3'd1;
          end
        end
        default: begin
          if (!ena) begin
            // Frame end: any partially shifted byte is dropped here.
            state_q  <= ST_IDLE;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            if (count_q != '0) begin
              frame_done <= 1'b1;
              frame_len  <= count_q;
              count_q    <= '0;
              if (DOUBLE_BUF != 0) begin
                recv_bank <= ~recv_bank;
              end
            end
          end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (w_byte_done) begin
              if ((state_q == ST_RECV) && (count_q < c_max_len)) begin
                recv_d    <= shift_d;
                recv_a    <= count_q[ADDR_W-1:0];
                count_q   <= count_q + 1'b1;
                pending_q <= 1'b1;
              end else begin
                state_q  <= ST_OVF;
                overflow <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_eth_rx_framer
//  Purpose  : Scoreboard bench driving two framer variants from one bit stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_framer;

  logic sck = 1'b0;
  logic n_rst = 1'b0;
  logic mosi = 1'b0;
  logic ena = 1'b0;

  // Variant 0: small buffer, LSB first, double buffered, MAX_LEN = depth.
  logic [7:0]  d0;
  logic [1:0]  a0;
  logic        b0, we0, fd0, ov0;
  logic [2:0]  fl0;
  // Variant 1: default sizes, MSB first, single bank.
  logic [7:0]  d1;
  logic [10:0] a1;
  logic        b1, we1, fd1, ov1;
  logic [11:0] fl1;

  eth_rx_framer #(.ADDR_W(2), .MAX_LEN(4), .MSB_FIRST(0), .DOUBLE_BUF(1)) u_dut0 (
    .sck(sck), .n_rst(n_rst), .mosi(mosi), .ena(ena),
    .recv_d(d0), .recv_a(a0), .recv_bank(b0), .n_recv_buf_we(we0),
    .frame_len(fl0), .frame_done(fd0), .overflow(ov0)
  );

  eth_rx_framer #(.MSB_FIRST(1)) u_dut1 (
    .sck(sck), .n_rst(n_rst), .mosi(mosi), .ena(ena),
    .recv_d(d1), .recv_a(a1), .recv_bank(b1), .n_recv_buf_we(we1),
    .frame_len(fl1), .frame_done(fd1), .overflow(ov1)
  );

  always #5 sck = ~sck;

  typedef struct { int bank; int addr; int data; } wr_t;
  typedef struct { int len; int ovf; } fr_t;

  wr_t wq0[$], wq1[$];
  fr_t fq0[$], fq1[$];
  logic [7:0] pat[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;
  int  bank_m[2] = '{0, 0};
  int  maxl_m[2] = '{4, 2048};
  int  msb_m[2]  = '{0, 1};
  int  dbl_m[2]  = '{1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic m, input logic e);
    @(negedge sck);
    #2;
    mosi = m;
    ena  = e;
  endtask

  // Reference model: a frame is a bit list; whole bytes are stored up to
  // MAX_LEN, anything beyond flags overflow, a trailing partial byte is lost.
  task automatic issue_frame(input int extra, input int gap);
    bit         bits[$];
    logic [7:0] val;
    int         nb;
    wr_t        w;
    fr_t        f;
    foreach (pat[i]) for (int j = 0; j < 8; j++) bits.push_back(pat[i][j]);
    for (int j = 0; j < extra; j++) bits.push_back(1'($urandom_range(0, 1)));
    nb = bits.size() / 8;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < nb; i++) begin
        val = 8'd0;
        for (int j = 0; j < 8; j++) begin
          if (msb_m[k] != 0) val[7-j] = bits[8*i+j];
          else               val[j]   = bits[8*i+j];
        end
        if (i < maxl_m[k]) begin
          w.bank = bank_m[k]; w.addr = i; w.data = int'(val);
          if (k == 0) wq0.push_back(w); else wq1.push_back(w);
        end
      end
      if (nb >= 1) begin
        f.len = (nb < maxl_m[k]) ? nb : maxl_m[k];
        f.ovf = (nb > maxl_m[k]) ? 1 : 0;
        if (k == 0) fq0.push_back(f); else fq1.push_back(f);
        if (dbl_m[k] != 0) bank_m[k] = 1 - bank_m[k];
      end
    end
    foreach (bits[i]) tick(bits[i], 1'b1);
    for (int j = 0; j < gap; j++) tick(1'($urandom_range(0, 1)), 1'b0);
  endtask

  always @(posedge we0) begin : mon_wr0
    wr_t e;
    if (mon_en) begin
      #1;
      if (wq0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL wr0_unexpected: got addr %0h data %0h, expected no strobe", a0, d0);
      end else begin
        e = wq0.pop_front();
        chk("wr0_data", d0, e.data);
        chk("wr0_addr", a0, e.addr);
        chk("wr0_bank", b0, e.bank);
      end
    end
  end

  always @(posedge we1) begin : mon_wr1
    wr_t e;
    if (mon_en) begin
      #1;
      if (wq1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL wr1_unexpected: got addr %0h data %0h, expected no strobe", a1, d1);
      end else begin
        e = wq1.pop_front();
        chk("wr1_data", d1, e.data);
        chk("wr1_addr", a1, e.addr);
        chk("wr1_bank", b1, e.bank);
      end
    end
  end

  always @(negedge sck) begin : mon_frame
    fr_t e;
    if (mon_en && fd0 !== 1'b0) begin
      if (fq0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL frame0_unexpected: got done=%b len %0d, expected none", fd0, fl0);
      end else begin
        e = fq0.pop_front();
        chk("frame0_len", fl0, e.len);
        chk("frame0_ovf", ov0, e.ovf);
      end
    end
    if (mon_en && fd1 !== 1'b0) begin
      if (fq1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL frame1_unexpected: got done=%b len %0d, expected none", fd1, fl1);
      end else begin
        e = fq1.pop_front();
        chk("frame1_len", fl1, e.len);
        chk("frame1_ovf", ov1, e.ovf);
      end
    end
  end

  initial begin
    repeat (3) @(negedge sck);
    chk("rst_d0", d0, 0);    chk("rst_a0", a0, 0);   chk("rst_bank0", b0, 0);
    chk("rst_we0", we0, 1);  chk("rst_len0", fl0, 0); chk("rst_done0", fd0, 0);
    chk("rst_ovf0", ov0, 0); chk("rst_we1", we1, 1); chk("rst_len1", fl1, 0);
    @(negedge sck);
    #2;
    n_rst  = 1'b1;
    mon_en = 1'b1;

    // Four byte-times with receive disabled: nothing may be written.
    for (int i = 0; i < 32; i++) tick(1'($urandom_range(0, 1)), 1'b0);

    pat = '{8'h10, 8'hd5, 8'h20, 8'hff, 8'h00, 8'ha5, 8'h73};
    issue_frame(0, 2);
    pat = '{8'hff, 8'h00, 8'ha5, 8'h73};
    issue_frame(0, 3);
    pat = '{8'ha5};
    issue_frame(0, 1);
    pat = '{8'hab};
    issue_frame(3, 2);
    pat.delete();
    issue_frame(5, 2);
    pat = '{8'h01, 8'h02, 8'h03};
    issue_frame(0, 2);
    pat = '{8'h04, 8'h05, 8'h06};
    issue_frame(0, 2);

    for (int n = 0; n < 40; n++) begin
      pat.delete();
      for (int i = 0, nb = $urandom_range(0, 7); i < nb; i++) pat.push_back(8'($urandom));
      issue_frame($urandom_range(0, 7), $urandom_range(1, 4));
    end

    // Reset asserted while a write strobe is active.
    for (int j = 0; j < 8; j++) tick(1'($urandom_range(0, 1)), 1'b1);
    @(posedge sck);
    @(negedge sck);
    #1;
    chk("strobe_low0", we0, 0);
    chk("strobe_low1", we1, 0);
    mon_en = 1'b0;
    n_rst  = 1'b0;
    #1;
    chk("rst_strobe_we0", we0, 1);
    chk("rst_strobe_we1", we1, 1);
    chk("rst_strobe_d0", d0, 0);
    chk("rst_strobe_bank0", b0, 0);
    ena = 1'b0;
    @(negedge sck);
    #2;
    n_rst = 1'b1;
    bank_m[0] = 0;
    bank_m[1] = 0;
    mon_en = 1'b1;

    pat = '{8'h3c, 8'hc3, 8'h5a};
    issue_frame(0, 2);

    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    chk("wq0_drained", wq0.size(), 0);
    chk("wq1_drained", wq1.size(), 0);
    chk("fq0_drained", fq0.size(), 0);
    chk("fq1_drained", fq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
